// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the tx serializer and the upcoming rx block.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

  // Clocks per bit, rounded to nearest.
  function automatic int cycles_per_bit(int clk_freq, int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: pulses tick once every CPB cycles, restartable by clear.
// Latency: tick is high in the CPB-th cycle after clear (count == CPB-1).
// Backpressure: none; free-running when not cleared.
module uart_baud_counter #(
  parameter int CPB = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [W-1:0] LAST = W'(CPB - 1);

  logic [W-1:0] cnt;

  // Count 0..CPB-1 and wrap; clear restarts the period from zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: 8N/E/O + 1/2 stop, LSB first, one byte per tx_start.
// Latency: start bit on the line 1 cycle after accept; tx_done N*CPB+1 cycles after accept.
// Backpressure: tx_start is ignored while tx_busy; no queuing.
module uart_tx_serializer #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  import uart_pkg::*;

  localparam int CPB      = cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam bit PAR_EN   = (PARITY != int'(PAR_NONE));
  localparam bit PAR_INV  = (PARITY == int'(PAR_ODD));
  localparam logic STOP_LAST = (STOP_BITS == 2);

  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_e state;
  logic [7:0]     shreg;
  logic [2:0]     bit_idx;
  logic           stop_idx;
  logic           par_bit;
  logic           accept;
  logic           tick;

  assign accept = (state == IDLE) && tx_start;

  // Restart the bit timer on accept so the start bit is exactly CPB cycles.
  uart_baud_counter #(.CPB(CPB)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .tick  (tick)
  );

  // Frame sequencer; tx/busy/done are registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            state    <= START;
            shreg    <= tx_data;
            // Parity is taken from the whole byte now, since the shifter is destructive.
            par_bit  <= (^tx_data) ^ PAR_INV;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              if (PAR_EN) begin
                state <= uart_pkg::PARITY;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end
        end
        uart_pkg::PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_idx == STOP_LAST) begin
              state   <= IDLE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
            tx <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: four serializer configurations side by side, table vectors,
// random bytes against a frame-level model, and hand sequences for the corner cases.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_uart_tx_serializer;

  localparam int CPB = 10;
  localparam int PAR_T  [4] = '{0, 1, 2, 0};
  localparam int STOP_T [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] start_v = '0;
  logic [3:0] tx_v, busy_v, done_v;
  logic [7:0] data_v [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_serializer #(
      .CLK_FREQ  (1_000_000),
      .BAUD_RATE (100_000),
      .PARITY    (PAR_T[g]),
      .STOP_BITS (STOP_T[g])
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .tx_start (start_v[g]),
      .tx_data  (data_v[g]),
      .tx       (tx_v[g]),
      .tx_busy  (busy_v[g]),
      .tx_done  (done_v[g])
    );
  end

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         exp_lat;
    int         par_pos;
    logic       exp_par;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: list of line levels, one per bit period.
  task automatic model_frame(input int i, input logic [7:0] d,
                             output logic bits [12], output int n);
    int ones;
    ones = 0;
    for (int k = 0; k < 12; k++) bits[k] = 1'b1;
    bits[0] = 1'b0;
    n = 1;
    for (int k = 0; k < 8; k++) begin
      bits[n] = d[k];
      ones += int'(d[k]);
      n++;
    end
    if (PAR_T[i] == 1) begin
      bits[n] = (ones % 2 == 1);
      n++;
    end else if (PAR_T[i] == 2) begin
      bits[n] = (ones % 2 == 0);
      n++;
    end
    n += STOP_T[i];
  endtask

  task automatic accept(input int i, input logic [7:0] d);
    @(negedge clk);
    start_v[i] = 1'b1;
    data_v[i]  = d;
    @(posedge clk);
  endtask

  // Called just after the accept edge; ends at the falling edge of the tx_done cycle.
  task automatic check_frame(input int i, input logic [7:0] d, input int exp_lat,
                             input int par_pos, input logic exp_par,
                             input bit next_vld, input logic [7:0] next_d,
                             input int junk_at, input logic [7:0] junk_d,
                             input string tag);
    logic bits [12];
    int   n, lat, done_cnt;
    model_frame(i, d, bits, n);
    lat = -1;
    done_cnt = 0;
    for (int j = 0; j <= n * CPB; j++) begin
      @(negedge clk);
      if (j == 0) begin
        start_v[i] = 1'b0;
        data_v[i]  = 8'($urandom);
      end
      if (j == junk_at) begin
        start_v[i] = 1'b1;
        data_v[i]  = junk_d;
      end
      if (junk_at >= 0 && j == junk_at + 1) start_v[i] = 1'b0;
      if (done_v[i] === 1'b1) begin
        done_cnt++;
        if (lat < 0) lat = j + 1;
      end
      if (j < n * CPB) begin
        chk({tag, " tx"}, 32'(tx_v[i]), 32'(bits[j / CPB]));
        chk({tag, " busy"}, 32'(busy_v[i]), 32'd1);
      end else begin
        chk({tag, " tx_end"}, 32'(tx_v[i]), 32'd1);
        chk({tag, " busy_end"}, 32'(busy_v[i]), 32'd0);
      end
      if (par_pos >= 0 && j == par_pos * CPB + CPB / 2)
        chk({tag, " parity"}, 32'(tx_v[i]), 32'(exp_par));
      if (j == n * CPB && next_vld) begin
        start_v[i] = 1'b1;
        data_v[i]  = next_d;
      end
    end
    chk({tag, " done_lat"}, 32'(lat), 32'((exp_lat >= 0) ? exp_lat : n * CPB + 1));
    chk({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic idle_check(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        chk({tag, " tx"}, 32'(tx_v[i]), 32'd1);
        chk({tag, " busy"}, 32'(busy_v[i]), 32'd0);
        chk({tag, " done"}, 32'(done_v[i]), 32'd0);
      end
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         ri;

    tbl[0] = '{0, 8'hA5, 101, -1, 1'b0};
    tbl[1] = '{1, 8'h07, 111,  9, 1'b1};
    tbl[2] = '{2, 8'h07, 111,  9, 1'b0};
    tbl[3] = '{3, 8'h3C, 111, -1, 1'b0};
    tbl[4] = '{1, 8'hFF, 111,  9, 1'b0};
    tbl[5] = '{2, 8'h80, 111,  9, 1'b0};

    for (int i = 0; i < 4; i++) data_v[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset tx", 32'(tx_v[i]), 32'd1);
      chk("reset busy", 32'(busy_v[i]), 32'd0);
      chk("reset done", 32'(done_v[i]), 32'd0);
    end
    rst = 1'b0;
    idle_check(50, "idle");

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      accept(tbl[v].inst, tbl[v].data);
      check_frame(tbl[v].inst, tbl[v].data, tbl[v].exp_lat, tbl[v].par_pos,
                  tbl[v].exp_par, 1'b0, 8'h00, -1, 8'h00, $sformatf("vec%0d", v));
    end

    // Back-to-back with two stop bits: second start in the tx_done cycle
    accept(3, 8'h00);
    check_frame(3, 8'h00, 111, -1, 1'b0, 1'b1, 8'hFF, -1, 8'h00, "b2b0");
    @(posedge clk);
    check_frame(3, 8'hFF, 111, -1, 1'b0, 1'b0, 8'h00, -1, 8'h00, "b2b1");

    // Start request while busy is dropped, not queued
    accept(0, 8'h81);
    check_frame(0, 8'h81, 101, -1, 1'b0, 1'b0, 8'h00, 34, 8'h3C, "ignore");
    idle_check(15, "ignore_after");

    // Reset in the middle of a frame
    accept(0, 8'hC3);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) start_v[0] = 1'b0;
      if (j == 39) begin
        chk("midrst pre tx", 32'(tx_v[0]), 32'd0);
        chk("midrst pre busy", 32'(busy_v[0]), 32'd1);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    chk("midrst tx", 32'(tx_v[0]), 32'd1);
    chk("midrst busy", 32'(busy_v[0]), 32'd0);
    chk("midrst done", 32'(done_v[0]), 32'd0);
    rst = 1'b0;
    idle_check(120, "midrst_after");
    accept(0, 8'h55);
    check_frame(0, 8'h55, 101, -1, 1'b0, 1'b0, 8'h00, -1, 8'h00, "post_rst");

    // Random bytes on random configurations
    for (int r = 0; r < 12; r++) begin
      ri = $urandom_range(0, 3);
      rd = 8'($urandom);
      accept(ri, rd);
      check_frame(ri, rd, -1, -1, 1'b0, 1'b0, 8'h00, -1, 8'h00, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
